// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT0 receive path.
// The CRC constants match the transmit-side CRC-16 generator.
package sd_dat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_END
  } state_e;

  localparam int unsigned CRC_W   = 16;
  localparam int unsigned CRC_CNT_W = 4;

  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC16_INIT = 16'h0000;

  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

endpackage

// File: rtl/sd_crc16_chk.sv
// Serial CRC-16 (x^16+x^12+x^5+1) LFSR, bit-identical to the transmit generator,
// with a synchronous clear added for per-block restart.
module sd_crc16_chk
  import sd_dat_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  assign fb = bit_i ^ crc_o[CRC_W-1];

  // Clear wins over enable so a block always starts from the init value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_o <= CRC16_INIT;
    end else if (clr) begin
      crc_o <= CRC16_INIT;
    end else if (en) begin
      crc_o <= {crc_o[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : CRC_W'(0));
    end
  end

endmodule

// File: rtl/sd_dat_rx_crc.sv
// Single-lane SD read-block receiver: start bit, N bytes MSB-first, CRC-16, end bit.
// Streams bytes to the block buffer and reports status to the data-path controller.
module sd_dat_rx_crc
  import sd_dat_pkg::*;
#(
  parameter int unsigned LEN_W = 12,
  parameter int unsigned TO_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] blk_len_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             dat_i,
  output logic [7:0]       byte_o,
  output logic             byte_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             crc_err_o,
  output logic             end_err_o,
  output logic             to_err_o,
  output logic             len_err_o
);

  localparam int unsigned BIT_W = LEN_W + 3;

  state_e state, state_nxt;

  logic [LEN_W-1:0]     len_q;
  logic [TO_W-1:0]      to_q;
  logic [TO_W-1:0]      to_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [6:0]           shift_q;
  logic [CRC_CNT_W-1:0] crc_cnt;
  logic [CRC_W-1:0]     rx_crc;
  logic [CRC_W-1:0]     crc_calc;
  logic                 done_pend;

  logic len_zero_c;
  logic to_hit_c;
  logic last_bit_c;
  logic byte_end_c;
  logic crc_last_c;

  logic load_c;
  logic crc_clr_c;
  logic crc_en_c;
  logic byte_fire_c;
  logic timeout_c;
  logic finish_c;
  logic len_fail_c;

  assign len_zero_c = (blk_len_i == '0);
  assign to_hit_c   = (dat_i != START_BIT) && (to_q != '0) &&
                      ((to_cnt + TO_W'(1)) == to_q);
  assign last_bit_c = (bit_cnt == ({len_q, 3'b000} - BIT_W'(1)));
  assign byte_end_c = (bit_cnt[2:0] == 3'd7);
  assign crc_last_c = (crc_cnt == CRC_CNT_W'(CRC_W - 1));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (arm_i && !len_zero_c) state_nxt = ST_WAIT_START;
        ST_WAIT_START: begin
          if (dat_i == START_BIT) begin
            state_nxt = ST_DATA;
          end else if (to_hit_c) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DATA:       if (last_bit_c) state_nxt = ST_CRC;
        ST_CRC:        if (crc_last_c) state_nxt = ST_END;
        ST_END:        state_nxt = ST_IDLE;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-state control strobes; all suppressed by abort
  always_comb begin
    load_c      = 1'b0;
    crc_clr_c   = 1'b0;
    crc_en_c    = 1'b0;
    byte_fire_c = 1'b0;
    timeout_c   = 1'b0;
    finish_c    = 1'b0;
    len_fail_c  = 1'b0;
    if (!abort_i) begin
      case (state)
        ST_IDLE: begin
          if (arm_i) begin
            load_c     = 1'b1;
            crc_clr_c  = 1'b1;
            len_fail_c = len_zero_c;
          end
        end
        ST_WAIT_START: timeout_c = to_hit_c;
        ST_DATA: begin
          crc_en_c    = 1'b1;
          byte_fire_c = byte_end_c;
        end
        ST_END:  finish_c = 1'b1;
        default: ;
      endcase
    end
  end

  sd_crc16_chk u_crc (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (crc_clr_c),
    .en    (crc_en_c),
    .bit_i (dat_i),
    .crc_o (crc_calc)
  );

  // Datapath: counters, shifters, status flags. Terminal events set their flags
  // first and raise done_o one cycle later, so done_o always sees settled flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q      <= '0;
      to_q       <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      crc_cnt    <= '0;
      rx_crc     <= '0;
      done_pend  <= 1'b0;
      byte_o     <= '0;
      byte_vld_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      crc_err_o  <= 1'b0;
      end_err_o  <= 1'b0;
      to_err_o   <= 1'b0;
      len_err_o  <= 1'b0;
    end else begin
      byte_vld_o <= byte_fire_c;
      busy_o     <= (state_nxt != ST_IDLE);
      done_o     <= done_pend && !abort_i;
      done_pend  <= finish_c || timeout_c || len_fail_c;

      if (byte_fire_c) begin
        byte_o <= {shift_q, dat_i};
      end

      if (load_c) begin
        len_q     <= blk_len_i;
        to_q      <= timeout_i;
        to_cnt    <= '0;
        bit_cnt   <= '0;
        crc_cnt   <= '0;
        crc_err_o <= 1'b0;
        end_err_o <= 1'b0;
        to_err_o  <= 1'b0;
        len_err_o <= len_zero_c;
      end

      if (state == ST_WAIT_START && dat_i != START_BIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (state == ST_DATA) begin
        shift_q <= {shift_q[5:0], dat_i};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (state == ST_CRC) begin
        rx_crc  <= {rx_crc[CRC_W-2:0], dat_i};
        crc_cnt <= crc_cnt + CRC_CNT_W'(1);
      end

      if (timeout_c) begin
        to_err_o <= 1'b1;
      end

      if (finish_c) begin
        end_err_o <= (dat_i != END_BIT);
        crc_err_o <= (rx_crc != crc_calc);
      end
    end
  end

endmodule

// File: tb/tb_sd_dat_rx_crc.sv
// Self-checking bench for sd_dat_rx_crc: directed and random read blocks
// compared against a polynomial-division CRC reference and a byte scoreboard.
module tb_sd_dat_rx_crc;

  localparam int unsigned LEN_W = 12;
  localparam int unsigned TO_W  = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             arm_i;
  logic             abort_i;
  logic [LEN_W-1:0] blk_len_i;
  logic [TO_W-1:0]  timeout_i;
  logic             dat_i;
  logic [7:0]       byte_o;
  logic             byte_vld_o;
  logic             busy_o;
  logic             done_o;
  logic             crc_err_o;
  logic             end_err_o;
  logic             to_err_o;
  logic             len_err_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned cyc = 0;
  int unsigned arm_cyc;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_vld_cyc = 0;
  logic        d_crc, d_end, d_to, d_len;
  logic [7:0]  rx_q[$];

  always #5 CLK = ~CLK;

  sd_dat_rx_crc #(.LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .arm_i      (arm_i),
    .abort_i    (abort_i),
    .blk_len_i  (blk_len_i),
    .timeout_i  (timeout_i),
    .dat_i      (dat_i),
    .byte_o     (byte_o),
    .byte_vld_o (byte_vld_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .crc_err_o  (crc_err_o),
    .end_err_o  (end_err_o),
    .to_err_o   (to_err_o),
    .len_err_o  (len_err_o)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard capture on the inactive edge
  always @(negedge CLK) begin
    if (byte_vld_o) begin
      rx_q.push_back(byte_o);
      last_vld_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      d_crc = crc_err_o;
      d_end = end_err_o;
      d_to  = to_err_o;
      d_len = len_err_o;
    end
  end

  // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] ref_crc(input logic [7:0] data[$]);
    bit          poly_div[$];
    logic [15:0] rem;
    int unsigned n;
    n = 8 * data.size();
    foreach (data[i]) for (int b = 7; b >= 0; b--) poly_div.push_back(data[i][b]);
    repeat (16) poly_div.push_back(1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      if (poly_div[i]) begin
        poly_div[i]      ^= 1'b1;
        poly_div[i + 4]  ^= 1'b1;
        poly_div[i + 11] ^= 1'b1;
        poly_div[i + 16] ^= 1'b1;
      end
    end
    for (int k = 0; k < 16; k++) rem[15 - k] = poly_div[n + k];
    return rem;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm_block(input int unsigned len, input logic [TO_W-1:0] to);
    blk_len_i = LEN_W'(len);
    timeout_i = to;
    arm_i     = 1'b1;
    dat_i     = 1'b1;
    tick();
    arm_cyc = cyc;
    arm_i   = 1'b0;
  endtask

  // Start bit after 'gap' idle ones, then payload; optional stray arm while busy
  task automatic send_payload(input logic [7:0] data[$], input int unsigned gap,
                              input int stray_at);
    int idx;
    repeat (gap) tick();
    dat_i = 1'b0;
    tick();
    idx = 0;
    foreach (data[i]) begin
      for (int b = 7; b >= 0; b--) begin
        dat_i = data[i][b];
        if (idx == stray_at) begin
          arm_i     = 1'b1;
          blk_len_i = '0;
        end
        tick();
        arm_i = 1'b0;
        idx++;
      end
    end
  endtask

  task automatic send_tail(input logic [15:0] crc, input logic end_bit);
    for (int b = 15; b >= 0; b--) begin
      dat_i = crc[b];
      tick();
    end
    dat_i = end_bit;
    tick();
    dat_i = 1'b1;
  endtask

  task automatic wait_done(input int unsigned prev, input string name);
    for (int i = 0; i < 40 && done_cnt == prev; i++) tick();
    if (done_cnt == prev) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: done_o not seen within 40 cycles", name);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    n_tests++; if (byte_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", byte_vld_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_tests++; if (byte_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", byte_o); end
    n_tests++;
    if ({crc_err_o, end_err_o, to_err_o, len_err_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {crc_err_o, end_err_o, to_err_o, len_err_o});
    end
    RST = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_all_ff(input logic [15:0] crc, input logic exp_crc_err, input string name);
    logic [7:0]  data[$];
    int unsigned prev, bad;
    repeat (512) data.push_back(8'hFF);
    rx_q.delete();
    prev = done_cnt;
    arm_block(512, 16'd0);
    send_payload(data, 3, -1);
    send_tail(crc, 1'b1);
    wait_done(prev, name);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i] !== 8'hFF) bad++;
    n_tests++; if (rx_q.size() != 512) begin n_fail++; $display("FAIL %s_count: got %0d want 512", name, rx_q.size()); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL %s_bytes: %0d bytes not FF", name, bad); end
    n_tests++; if (done_cnt != prev + 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want %0d", name, done_cnt - prev, 1); end
    n_tests++; if (d_crc !== exp_crc_err) begin n_fail++; $display("FAIL %s_crc_err: got %b want %b", name, d_crc, exp_crc_err); end
    n_tests++; if (d_end !== 1'b0) begin n_fail++; $display("FAIL %s_end_err: got %b want 0", name, d_end); end
    n_tests++; if (done_cyc - last_vld_cyc != 18) begin n_fail++; $display("FAIL %s_latency: got %0d want 18", name, done_cyc - last_vld_cyc); end
  endtask

  task automatic test_single_byte();
    logic [7:0]  data[$];
    int unsigned prev;
    data.push_back(8'hA5);
    rx_q.delete();
    prev = done_cnt;
    arm_block(1, 16'd50);
    send_payload(data, 0, -1);
    send_tail(ref_crc(data), 1'b0);
    wait_done(prev, "single");
    n_tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got size %0d first %h want A5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    n_tests++; if (d_end !== 1'b1) begin n_fail++; $display("FAIL single_end_err: got %b want 1", d_end); end
    n_tests++; if (d_crc !== 1'b0) begin n_fail++; $display("FAIL single_crc_err: got %b want 0", d_crc); end
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [7:0]  data[$];
      logic [15:0] crc;
      logic        corrupt, end_bit;
      int unsigned len, gap, prev, bad;
      int          stray;
      len     = $urandom_range(1, 24);
      gap     = $urandom_range(0, 6);
      for (int i = 0; i < int'(len); i++) data.push_back(8'($urandom));
      crc     = ref_crc(data);
      corrupt = ($urandom_range(0, 2) == 0);
      if (corrupt) crc[$urandom_range(0, 15)] ^= 1'b1;
      end_bit = 1'($urandom_range(0, 1));
      stray   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * len - 1)) : -1;
      rx_q.delete();
      prev = done_cnt;
      arm_block(len, ($urandom_range(0, 1) == 1) ? TO_W'(gap + 1 + $urandom_range(0, 40)) : TO_W'(0));
      send_payload(data, gap, stray);
      send_tail(crc, end_bit);
      wait_done(prev, "random");
      bad = 0;
      foreach (data[i]) if (i >= rx_q.size() || rx_q[i] !== data[i]) bad++;
      n_tests++; if (bad != 0 || rx_q.size() != len) begin n_fail++; $display("FAIL random_bytes: it %0d len %0d got %0d bytes, %0d wrong", it, len, rx_q.size(), bad); end
      n_tests++;
      if ({d_crc, d_end, d_to, d_len} !== {corrupt, ~end_bit, 2'b00}) begin
        n_fail++;
        $display("FAIL random_flags: it %0d got %b want %b", it, {d_crc, d_end, d_to, d_len}, {corrupt, ~end_bit, 2'b00});
      end
      n_tests++; if (done_cnt != prev + 1) begin n_fail++; $display("FAIL random_done_cnt: it %0d got %0d want 1", it, done_cnt - prev); end
      n_tests++; if (done_cyc - last_vld_cyc != 18) begin n_fail++; $display("FAIL random_latency: it %0d got %0d want 18", it, done_cyc - last_vld_cyc); end
    end
  endtask

  task automatic test_timeout();
    int unsigned prev;
    rx_q.delete();
    prev = done_cnt;
    arm_block(8, 16'd100);
    for (int i = 0; i < 120 && done_cnt == prev; i++) tick();
    n_tests++; if (done_cnt != prev + 1) begin n_fail++; $display("FAIL timeout_done: got %0d pulses want 1", done_cnt - prev); end
    n_tests++; if (done_cyc - arm_cyc != 101) begin n_fail++; $display("FAIL timeout_latency: got %0d want 101", done_cyc - arm_cyc); end
    n_tests++; if (d_to !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", d_to); end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL timeout_bytes: got %0d want 0", rx_q.size()); end
    repeat (2) tick();
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_len_zero();
    int unsigned prev;
    logic        busy_seen;
    prev = done_cnt;
    arm_block(0, 16'd10);
    busy_seen = busy_o;
    n_tests++; if (len_err_o !== 1'b1) begin n_fail++; $display("FAIL len0_flag: got %b want 1", len_err_o); end
    tick();
    busy_seen |= busy_o;
    n_tests++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done_o); end
    repeat (3) begin tick(); busy_seen |= busy_o; end
    n_tests++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", busy_seen); end
    n_tests++; if (done_cnt != prev + 1) begin n_fail++; $display("FAIL len0_done_cnt: got %0d want 1", done_cnt - prev); end
  endtask

  task automatic test_abort_rearm();
    logic [7:0]  big[$];
    logic [7:0]  part[$];
    logic [7:0]  data[$];
    int unsigned prev, bad;
    for (int i = 0; i < 512; i++) big.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) part.push_back(big[i]);
    rx_q.delete();
    prev = done_cnt;
    arm_block(512, 16'd0);
    send_payload(part, 2, -1);
    for (int b = 7; b >= 4; b--) begin dat_i = big[3][b]; tick(); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    dat_i   = 1'b1;
    repeat (30) tick();
    n_tests++; if (done_cnt != prev) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt - prev); end
    n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL abort_bytes: got %0d want 3", rx_q.size()); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    for (int i = 0; i < 4; i++) data.push_back(8'($urandom));
    rx_q.delete();
    arm_block(4, 16'd0);
    send_payload(data, 1, -1);
    send_tail(ref_crc(data), 1'b1);
    wait_done(prev, "rearm");
    bad = 0;
    foreach (data[i]) if (i >= rx_q.size() || rx_q[i] !== data[i]) bad++;
    n_tests++; if (bad != 0 || rx_q.size() != 4) begin n_fail++; $display("FAIL rearm_bytes: got %0d bytes, %0d wrong", rx_q.size(), bad); end
    n_tests++; if (d_crc !== 1'b0) begin n_fail++; $display("FAIL rearm_crc_err: got %b want 0", d_crc); end
    n_tests++; if (done_cnt != prev + 1) begin n_fail++; $display("FAIL rearm_done_cnt: got %0d want 1", done_cnt - prev); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] data[$];
    for (int i = 0; i < 8; i++) data.push_back(8'($urandom));
    data[0] = 8'h3C;
    arm_block(8, 16'd0);
    send_payload(data[0:0], 0, -1);
    n_tests++; if (byte_vld_o !== 1'b1 || byte_o !== 8'h3C) begin n_fail++; $display("FAIL rst_pre: vld %b byte %h want 1 3C", byte_vld_o, byte_o); end
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if ({byte_o, byte_vld_o, busy_o, done_o, crc_err_o, end_err_o, to_err_o, len_err_o} !== 15'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got byte %h vld %b busy %b done %b flags %b want all 0",
               byte_o, byte_vld_o, busy_o, done_o, {crc_err_o, end_err_o, to_err_o, len_err_o});
    end
    repeat (2) tick();
    RST = 1'b0;
    repeat (3) tick();
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_busy: got %b want 0", busy_o); end
  endtask

  initial begin
    RST       = 1'b1;
    arm_i     = 1'b0;
    abort_i   = 1'b0;
    blk_len_i = '0;
    timeout_i = '0;
    dat_i     = 1'b1;
    test_reset();
    test_all_ff(16'h7FA1, 1'b0, "ff512");
    test_all_ff(16'h7FA0, 1'b1, "ff512_badcrc");
    test_single_byte();
    test_timeout();
    test_len_zero();
    test_random(8);
    test_abort_rearm();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_dat_rx_crc.md
Name: sd_dat_rx_crc

Overview:
- Single-lane SD data receiver. Captures one read data block on DAT0: start bit, N data bytes MSB-first, 16-bit CRC, end bit.
- Checks the received CRC against a locally computed CRC-16 (x^16+x^12+x^5+1, init 0). This uses the same polynomial and bit ordering as the team's transmit-side CRC-16 generator.
- Sits between the SD pad/sampling stage and the block buffer. It streams bytes out and reports status to the data-path controller.

Parameters:
- LEN_W, 12, width of block length in bytes (max 2^LEN_W - 1).
- TO_W, 16, width of start-bit timeout counter.

Ports:
- CLK  in  1  SD bit clock; dat_i sampled on rising edge.
- RST  in  1  asynchronous, active-high reset.
- arm_i  in  1  one-cycle pulse; start waiting for a block.
- abort_i  in  1  synchronous abort; return to IDLE.
- blk_len_i  in  LEN_W  block length in bytes; sampled on arm_i.
- timeout_i  in  TO_W  start-bit wait limit in cycles; sampled on arm_i.
- dat_i  in  1  serial DAT0 line.
- byte_o  out  8  assembled data byte.
- byte_vld_o  out  1  byte_o valid, one-cycle pulse.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at end of block or error.
- crc_err_o  out  1  received CRC differs from computed CRC.
- end_err_o  out  1  end bit sampled as 0.
- to_err_o  out  1  start bit not seen within timeout.
- len_err_o  out  1  arm_i with blk_len_i == 0.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, CRC 0.
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE:
  - On arm_i, latch blk_len_i and timeout_i, sync-clear the CRC, and clear all error flags.
  - If the length is 0: stay in IDLE, set len_err_o, pulse done_o next cycle. Otherwise go to WAIT_START.
- WAIT_START:
  - dat_i==0 -> DATA. The start bit is not fed to the CRC.
  - Otherwise the timeout counter increments. When it reaches the latched timeout, go to IDLE, set to_err_o and pulse done_o.
  - A timeout value of 0 disables the timeout.
- DATA:
  - Each cycle, shift dat_i into the byte register (MSB first) and feed dat_i to the CRC (enable=1).
  - After the 8th bit of a byte, byte_o/byte_vld_o are registered and valid the following cycle.
  - After bit 8*len, go to CRC.
  - CRC enable is 0 in every other state, so the computed value is frozen.
- CRC: shift 16 received bits MSB-first into rx_crc, then go to END.
- END:
  - Sample the end bit. If dat_i==0, set end_err_o.
  - Set crc_err_o if rx_crc != computed CRC.
  - Pulse done_o next cycle, go to IDLE.
  - The last byte_vld_o pulse precedes done_o by 18 cycles.
- Error flags hold until the next arm_i. done_o is exactly one cycle per arm.
- arm_i while busy_o is high: ignored.
- abort_i has priority over arm_i and all transitions. It goes to IDLE with no done_o and no byte_vld_o, and leaves flags unchanged.
- Bit counter width LEN_W+3 is required; byte count wrap is impossible by construction.
- Async RST mid-block: immediate return to reset values; no partial byte emitted.
- The CRC block is controlled only by a synchronous clear and an enable; it has no async clear path other than RST.

Decomposition:
- Package sd_dat_pkg holds:
  - state enum type;
  - CRC16_POLY = 16'h1021;
  - CRC16_INIT = 16'h0000;
  - START_BIT = 1'b0 and END_BIT = 1'b1 constants.
- Sub-module sd_crc16_chk: serial CRC-16 LFSR with CLK, RST, clr (sync), en, bit_i, crc_o[15:0]. Bit behaviour is identical to the transmit-side generator; it differs only in adding sync clear.

Test Plan:
- blk_len=512, data all 0xFF, CRC 16'h7FA1, end bit 1 -> 512 byte_vld_o pulses of 8'hFF; done_o with crc_err_o=0, end_err_o=0.
- Same block with the CRC LSB flipped (16'h7FA0) -> crc_err_o=1; all 512 bytes still delivered.
- blk_len=1, byte 8'hA5, correct CRC from the reference model, end bit 0 -> byte_o=8'hA5; end_err_o=1, crc_err_o=0.
- timeout=100, dat_i held 1 -> done_o at cycle ~101 after arm; to_err_o=1; no byte_vld_o.
- arm with blk_len=0 -> len_err_o=1 and done_o next cycle; busy_o stays 0.
- abort_i at byte 3 of a 512-byte block, then re-arm with a valid 4-byte block -> no done_o for the first block; second block completes with crc_err_o=0, proving the CRC was cleared. Also assert RST mid-DATA and check all outputs are 0 the same cycle.
